multicycle_controller: RTL and testbench

- Control unit for the multicycle MIPS core. It sits directly upstream of the datapath and drives every one of its control inputs.
- Consumes instr[31:26] (op), instr[5:0] (funct) and the datapath's zero flag.
- Moore main FSM for instruction sequencing, plus a combinational ALU decoder.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

---
 rtl/mips_ctrl_pkg.sv | 139 +++++++++++++
 rtl/multicycle_controller_alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 101 ++++++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct codes, ALU selects.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  // Main FSM states; codes 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } statetype;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop: how the ALU decoder picks the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-input selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC selects
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Per-state control word (Moore part of the controller).
  typedef struct packed {
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Control word for a state; unlisted fields stay at their idle defaults,
  // and unused state codes yield the all-idle word (no strobes).
  function automatic ctrl_t ctrl_decode(statetype s);
    ctrl_t c;
    c         = '0;
    c.alusrcb = SRCB_REG;
    c.pcsrc   = PC_ALURES;
    c.aluop   = ALUOP_ADD;
    case (s)
      FETCH: begin
        c.alusrcb = SRCB_FOUR;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = SRCB_IMMSH;  // branch target precompute
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = PC_JUMP;
        c.pcwrite = 1'b1;
        c.jump    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps aluop/funct to the 3-bit ALU operation and flags unknown funct codes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: aluop_i (00 add, 01 sub, 10 by funct), funct_i, alucontrol_o, bad_funct_o.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       bad_funct_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALU_ADD;
          FUNCT_SUB: alucontrol_o = ALU_SUB;
          FUNCT_AND: alucontrol_o = ALU_AND;
          FUNCT_OR:  alucontrol_o = ALU_OR;
          FUNCT_SLT: alucontrol_o = ALU_SLT;
          // Unknown funct still completes as an add; the top reports it.
          default:   bad_funct_o  = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder, drives all datapath controls.
// Latency: outputs follow the state register; pcen tracks zero and illegal tracks op/funct combinationally.
// Backpressure: none; one state per clock, reset forces FETCH with all write strobes low.
// Ports: clk, reset (sync, active-high), op, funct, zero in; datapath mux selects, alucontrol,
//        irwrite/regwrite/memwrite/pcen strobes, jump and illegal out.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       pcen,
  output logic       jump,
  output logic       illegal
);

  statetype state_q, state_d;
  ctrl_t    ctrl;
  logic     bad_funct;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // While reset is held the outputs look like FETCH but with every strobe
  // killed, so an instruction interrupted mid-flight cannot write anything.
  always_comb begin
    ctrl = ctrl_decode(state_q);
    if (reset) begin
      ctrl          = ctrl_decode(FETCH);
      ctrl.irwrite  = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.pcwrite  = 1'b0;
      ctrl.branch   = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop_i      (ctrl.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct)
  );

  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign iord     = ctrl.iord;
  assign alusrcA  = ctrl.alusrca;
  assign alusrcB  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign memwrite = ctrl.memwrite;
  assign jump     = ctrl.jump;
  assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);

  assign illegal = ~reset &
                   (((state_q == DECODE) & ~op_supported(op)) |
                    ((state_q == EXECUTE) & bad_funct));

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: steps through every instruction class and reset corners.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memtoreg, regdst, iord, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic       irwrite, regwrite, memwrite, pcen, jump, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .iord       (iord),
    .alusrcA    (alusrcA),
    .alusrcB    (alusrcB),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .pcen       (pcen),
    .jump       (jump),
    .illegal    (illegal)
  );

  // Observed outputs, packed in this order:
  // memtoreg regdst iord alusrcA alusrcB[1:0] pcsrc[1:0] alucontrol[2:0] irwrite regwrite memwrite pcen jump illegal
  logic [16:0] obs;
  assign obs = {memtoreg, regdst, iord, alusrcA, alusrcB, pcsrc, alucontrol,
                irwrite, regwrite, memwrite, pcen, jump, illegal};

  function automatic logic [16:0] mk(input logic m2r, input logic rd, input logic ird,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [2:0] alu, input logic irw, input logic rw,
                                     input logic mw, input logic pe, input logic jp, input logic il);
    return {m2r, rd, ird, sa, sb, ps, alu, irw, rw, mw, pe, jp, il};
  endfunction

  task automatic chk(input string tag, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output words per state, written from the state table.
  logic [16:0] E_RST, E_FETCH, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
  logic [16:0] E_EX_SUB, E_EX_AND, E_EX_BAD, E_ALUWB, E_BR_Z1, E_BR_Z0, E_ADDIEX, E_ADDIWB, E_JUMP;

  initial begin
    E_RST     = mk(0,0,0,0,2'b01,2'b00,3'b010,0,0,0,0,0,0);
    E_FETCH   = mk(0,0,0,0,2'b01,2'b00,3'b010,1,0,0,1,0,0);
    E_DEC     = mk(0,0,0,0,2'b11,2'b00,3'b010,0,0,0,0,0,0);
    E_DEC_ILL = mk(0,0,0,0,2'b11,2'b00,3'b010,0,0,0,0,0,1);
    E_MEMADR  = mk(0,0,0,1,2'b10,2'b00,3'b010,0,0,0,0,0,0);
    E_MEMRD   = mk(0,0,1,0,2'b00,2'b00,3'b010,0,0,0,0,0,0);
    E_MEMWB   = mk(1,0,0,0,2'b00,2'b00,3'b010,0,1,0,0,0,0);
    E_MEMWR   = mk(0,0,1,0,2'b00,2'b00,3'b010,0,0,1,0,0,0);
    E_EX_SUB  = mk(0,0,0,1,2'b00,2'b00,3'b110,0,0,0,0,0,0);
    E_EX_AND  = mk(0,0,0,1,2'b00,2'b00,3'b000,0,0,0,0,0,0);
    E_EX_BAD  = mk(0,0,0,1,2'b00,2'b00,3'b010,0,0,0,0,0,1);
    E_ALUWB   = mk(0,1,0,0,2'b00,2'b00,3'b010,0,1,0,0,0,0);
    E_BR_Z1   = mk(0,0,0,1,2'b00,2'b01,3'b110,0,0,0,1,0,0);
    E_BR_Z0   = mk(0,0,0,1,2'b00,2'b01,3'b110,0,0,0,0,0,0);
    E_ADDIEX  = mk(0,0,0,1,2'b10,2'b00,3'b010,0,0,0,0,0,0);
    E_ADDIWB  = mk(0,0,0,0,2'b00,2'b00,3'b010,0,1,0,0,0,0);
    E_JUMP    = mk(0,0,0,0,2'b00,2'b10,3'b010,0,0,0,1,1,0);

    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;

    // Reset held two cycles: no strobes, FETCH values otherwise.
    step(); chk("reset_c1", E_RST);
    step(); chk("reset_c2", E_RST);
    reset = 1'b0;
    #1; chk("first_fetch", E_FETCH);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB -> FETCH (5 cycles)
    op = 6'b100011;
    step(); chk("lw_decode", E_DEC);
    step(); chk("lw_memadr", E_MEMADR);
    step(); chk("lw_memrd", E_MEMRD);
    step(); chk("lw_memwb", E_MEMWB);
    step(); chk("lw_fetch", E_FETCH);

    // R-type sub (4 cycles)
    op = 6'b000000; funct = 6'b100010;
    step(); chk("sub_decode", E_DEC);
    step(); chk("sub_execute", E_EX_SUB);
    step(); chk("sub_aluwb", E_ALUWB);
    step(); chk("sub_fetch", E_FETCH);

    // R-type and
    funct = 6'b100100;
    step(); chk("and_decode", E_DEC);
    step(); chk("and_execute", E_EX_AND);
    step(); chk("and_aluwb", E_ALUWB);
    step(); chk("and_fetch", E_FETCH);

    // R-type with unknown funct: add + illegal in EXECUTE, still writes back
    funct = 6'b111111;
    step(); chk("badf_decode", E_DEC);
    step(); chk("badf_execute", E_EX_BAD);
    step(); chk("badf_aluwb", E_ALUWB);
    step(); chk("badf_fetch", E_FETCH);

    // beq taken (zero=1); pcen follows zero within the BRANCH cycle
    op = 6'b000100; funct = 6'b000000; zero = 1'b1;
    step(); chk("beq1_decode", E_DEC);
    step(); chk("beq1_branch", E_BR_Z1);
    zero = 1'b0;
    #1; chk("beq1_zero_drop", E_BR_Z0);
    step(); chk("beq1_fetch", E_FETCH);

    // beq not taken (zero=0)
    step(); chk("beq0_decode", E_DEC);
    step(); chk("beq0_branch", E_BR_Z0);
    step(); chk("beq0_fetch", E_FETCH);

    // j (3 cycles)
    op = 6'b000010;
    step(); chk("j_decode", E_DEC);
    step(); chk("j_jump", E_JUMP);
    step(); chk("j_fetch", E_FETCH);

    // addi (4 cycles)
    op = 6'b001000;
    step(); chk("addi_decode", E_DEC);
    step(); chk("addi_ex", E_ADDIEX);
    step(); chk("addi_wb", E_ADDIWB);
    step(); chk("addi_fetch", E_FETCH);

    // Unsupported opcode: illegal in DECODE, straight back to FETCH
    op = 6'b111111;
    step(); chk("ill_decode", E_DEC_ILL);
    step(); chk("ill_fetch", E_FETCH);

    // sw interrupted by reset in MEMADR: no memwrite, FETCH after the edge
    op = 6'b101011;
    step(); chk("swr_decode", E_DEC);
    step(); chk("swr_memadr", E_MEMADR);
    reset = 1'b1;
    #1; chk("swr_reset_in_memadr", E_RST);
    step(); chk("swr_reset_edge", E_RST);
    reset = 1'b0;
    #1; chk("swr_fetch", E_FETCH);

    // sw complete (4 cycles)
    step(); chk("sw_decode", E_DEC);
    step(); chk("sw_memadr", E_MEMADR);
    step(); chk("sw_memwr", E_MEMWR);
    step(); chk("sw_fetch", E_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
